// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter sharing one fifo producer port among N_REQ producers.
// A grant lasts up to MAX_BURST beats; every new grant costs one idle bubble.

module fifo_rr_arbiter_lane (
    input  logic sel,
    input  logic irdy,
    input  logic f_trdy,
    output logic trdy,
    output logic fwd_irdy
);
    // A non-owner lane is fully masked, so its irdy never reaches its trdy.
    assign fwd_irdy = sel & irdy;
    assign trdy     = sel & irdy & f_trdy;
endmodule

module fifo_rr_arbiter #(
    parameter int  N_REQ     = 4,
    parameter type T_        = logic [2:0],
    parameter int  MAX_BURST = 4,
    localparam int LOGN      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] p2a_irdy,
    output logic [N_REQ-1:0] a2p_trdy,
    input  T_                p_data [N_REQ],
    output logic             a2f_irdy,
    input  logic             f2a_trdy,
    output T_                data_out,
    output logic             grant_vld,
    output logic [LOGN-1:0]  grant_id
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [LOGN-1:0] owner;
    logic [LOGN-1:0] rr_ptr;
    logic [CW-1:0]   burst_cnt;

    logic [N_REQ-1:0] lane_irdy;
    logic [LOGN-1:0]  pick;
    logic [LOGN-1:0]  nxt_owner;
    logic             owner_irdy;
    logic             beat;
    logic             last_beat;
    logic             found;
    int               idx;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        fifo_rr_arbiter_lane u_lane (
            .sel      (grant_vld && (owner == LOGN'(i))),
            .irdy     (p2a_irdy[i]),
            .f_trdy   (f2a_trdy),
            .trdy     (a2p_trdy[i]),
            .fwd_irdy (lane_irdy[i])
        );
    end

    assign a2f_irdy   = |lane_irdy;
    assign data_out   = grant_vld ? p_data[owner] : '0;
    assign owner_irdy = p2a_irdy[owner];
    assign beat       = grant_vld & owner_irdy & f2a_trdy;
    assign last_beat  = (burst_cnt == CW'(MAX_BURST - 1));
    assign nxt_owner  = (owner == LOGN'(N_REQ - 1)) ? '0 : owner + LOGN'(1);

    // First requester at or after rr_ptr, wrapping by compare so N_REQ need not be 2^n.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && p2a_irdy[idx]) begin
                found = 1'b1;
                pick  = LOGN'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant_vld <= 1'b0;
            grant_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|p2a_irdy) begin
                        state     <= GRANT;
                        owner     <= pick;
                        grant_id  <= pick;
                        grant_vld <= 1'b1;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_irdy || (beat && last_beat)) begin
                        state     <= IDLE;
                        rr_ptr    <= nxt_owner;
                        grant_vld <= 1'b0;
                        grant_id  <= '0;
                    end else if (beat) begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
